pipe_flow_tracer: RTL and testbench
===================================

// Module: pipe_flow_tracer
// PURPOSE
//  Sequencer that checks whether the current 6x6 pipe grid carries flow from the left edge of cell (0,0)
//  to the right edge of cell (END_X,END_Y). It walks the grid one cell at a time and shares the grid
//  read port with the renderer through a req/gnt handshake. It sits beside the move/swap datapath and
//  is started by the game controller after each swap. It reports solved/fail, the step count and the
//  coordinates of the last cell examined.
// PARAMETERS
//  GRID_W     6   grid columns (x = 0..GRID_W-1)
//  GRID_H     6   grid rows (y = 0..GRID_H-1)
//  END_X      5   exit cell x; flow must leave this cell through its RIGHT side
//  END_Y      5   exit cell y
//  MAX_STEPS  36  cell-visit cap; reaching it without an exit = fail (loop guard)
// PORTS
//  clk       in   1  system clock (CLOCK_50)
//  reset     in   1  synchronous, active-high reset
//  start     in   1  1-cycle pulse: begin trace; ignored while busy
//  rd_req    out  1  grid read request; held high until rd_gnt is sampled high
//  rd_x      out  4  requested cell x; stable while rd_req=1
//  rd_y      out  4  requested cell y; stable while rd_req=1
//  rd_gnt    in   1  grid arbiter grant for the current request
//  rd_data   in   3  pipe code of (rd_x,rd_y); valid in the cycle after rd_gnt
//  busy      out  1  high from the cycle after start until done
//  done      out  1  1-cycle pulse when the trace finishes
//  solved    out  1  result; valid from done until the next accepted start
//  steps     out  6  number of cells entered through a valid opening
//  fail_x    out  4  x of the last cell read (fail point, or END_X when solved)
//  fail_y    out  4  y of the last cell read
// BEHAVIOUR
//  Clock and reset: single clock domain; reset is synchronous and active-high.
//  Pipe codes (openings):
//   0 none; 1 L-R; 2 U-D; 3 U-R; 4 R-D; 5 D-L; 6 L-U; 7 none.
//   y increases downward (up = y-1).
//  Reset: state=IDLE. rd_req, busy, done and solved are 0. steps, fail_x, fail_y, rd_x and rd_y are 0.
//   Reset wins over every other input, including mid-trace. rd_req is low in the cycle after reset is
//   sampled.
//  FSM:
//   IDLE:  on start: cur=(0,0), entry=LEFT, steps=0, solved=0, busy=1 -> REQ.
//   REQ:   rd_req=1, rd_x/rd_y=cur. If rd_gnt is sampled 1 -> WAIT. Otherwise stay; no timeout.
//   WAIT:  rd_req=0. Register rd_data into pipe_r -> EVAL.
//   EVAL:  combinational decode of pipe_r vs entry:
//    - entry side not an opening of pipe_r -> FAIL.
//    - otherwise steps+1 and exit = other opening.
//    - cur==(END_X,END_Y) and exit==RIGHT -> PASS.
//    - neighbour in exit direction outside grid -> FAIL.
//    - steps+1 == MAX_STEPS -> FAIL.
//    - else cur=neighbour, entry=opposite(exit) -> REQ.
//   PASS/FAIL: solved=1/0, fail_x/fail_y=cur, busy=0, done=1 for one cycle -> IDLE.
//  Latency: minimum 3 cycles per cell (REQ with immediate grant, WAIT, EVAL) plus 1 cycle for PASS/FAIL.
//  Field update rule: steps, fail_x/fail_y and solved only update at PASS/FAIL and at an accepted start.
//   They hold between traces.
//  Arithmetic: x/y are 4-bit unsigned. The out-of-grid test covers x==0 moving left, y==0 moving up,
//   x==GRID_W-1 moving right (unless at the end cell), and y==GRID_H-1 moving down. There is no
//   wrap-around.
//  Simultaneous events: start together with reset -> reset. start in any state other than IDLE is
//   dropped, not queued. Reset during REQ drops the request; the arbiter treats a dropped request
//   as a no-op.
// TESTING
//  1 Reset mid-trace (in REQ, waiting for grant) -> next cycle: rd_req=0, busy=0, done=0;
//    a later start with the all-1 grid gives a normal trace.
//  2 Solved path: row0 = 1,1,1,1,1,5; (5,1)..(5,4) = 2; (5,5) = 3; rd_gnt tied 1
//    -> done with solved=1, steps=11, fail=(5,5); busy high for 11*3 cycles.
//  3 Blocked entry: (0,0)=2 -> solved=0, steps=0, fail=(0,0); exactly one rd_req.
//  4 Off-grid exit: (0,0)=1, (1,0)=6 -> exit up from y=0 -> solved=0, steps=2, fail=(1,0).
//  5 Grant stall: withhold rd_gnt for 5 cycles on the 2nd cell -> rd_req and rd_x=1/rd_y=0 stay stable;
//    the result matches scenario 2; start pulsed while busy is ignored.
//  6 Wrong final exit: as scenario 2 but (5,5)=2 -> exit down off-grid -> solved=0, steps=11, fail=(5,5).

Source files
------------

// File: rtl/pipe_flow_tracer.sv
// Walks the pipe grid from the left edge of (0,0) and reports whether flow reaches the right edge of (END_X,END_Y).
// Latency: 3 cycles per cell (REQ with immediate grant, WAIT, EVAL) plus 1 result cycle (PASS/FAIL).
// Backpressure: o_rd_req and o_rd_x/o_rd_y hold indefinitely until i_rd_gnt is sampled; start is dropped while busy.
module pipe_flow_tracer #(
   parameter int GRID_W    = 6,
   parameter int GRID_H    = 6,
   parameter int END_X     = 5,
   parameter int END_Y     = 5,
   parameter int MAX_STEPS = 36
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   output logic       o_rd_req,
   output logic [3:0] o_rd_x,
   output logic [3:0] o_rd_y,
   input  logic       i_rd_gnt,
   input  logic [2:0] i_rd_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_solved,
   output logic [5:0] o_steps,
   output logic [3:0] o_fail_x,
   output logic [3:0] o_fail_y
);

   // Sides double as bit positions in the opening mask; opposite side = side ^ 2.
   localparam logic [1:0] SIDE_L = 2'd0;
   localparam logic [1:0] SIDE_U = 2'd1;
   localparam logic [1:0] SIDE_R = 2'd2;
   localparam logic [1:0] SIDE_D = 2'd3;

   localparam logic [3:0] LP_X_MAX = 4'(GRID_W - 1);
   localparam logic [3:0] LP_Y_MAX = 4'(GRID_H - 1);
   localparam logic [3:0] LP_END_X = 4'(END_X);
   localparam logic [3:0] LP_END_Y = 4'(END_Y);
   localparam logic [5:0] LP_MAX   = 6'(MAX_STEPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_EVAL,
      S_PASS,
      S_FAIL
   } state_t;

   state_t     r_state;
   state_t     w_next_state;

   logic [3:0] r_cur_x;
   logic [3:0] r_cur_y;
   logic [1:0] r_entry;
   logic [2:0] r_pipe;
   logic [5:0] r_cnt;
   logic       r_solved;
   logic [5:0] r_steps;
   logic [3:0] r_fail_x;
   logic [3:0] r_fail_y;

   logic [3:0] w_open;
   logic [3:0] w_exit_mask;
   logic [1:0] w_exit;
   logic       w_entry_ok;
   logic       w_at_end;
   logic       w_off_grid;
   logic [5:0] w_cnt_inc;
   logic [3:0] w_nbr_x;
   logic [3:0] w_nbr_y;

   // Decode the latched pipe against the entry side: openings, exit side, neighbour and edge test.
   always_comb begin
      w_open      = 4'b0000;
      w_exit      = SIDE_L;
      w_off_grid  = 1'b0;
      w_nbr_x     = r_cur_x;
      w_nbr_y     = r_cur_y;
      case (r_pipe)
         3'd1:    w_open = 4'b0101; // L-R
         3'd2:    w_open = 4'b1010; // U-D
         3'd3:    w_open = 4'b0110; // U-R
         3'd4:    w_open = 4'b1100; // R-D
         3'd5:    w_open = 4'b1001; // D-L
         3'd6:    w_open = 4'b0011; // L-U
         default: w_open = 4'b0000; // 0 and 7 have no openings
      endcase
      w_entry_ok  = w_open[r_entry];
      w_exit_mask = w_open & ~(4'b0001 << r_entry);
      case (w_exit_mask)
         4'b0010: w_exit = SIDE_U;
         4'b0100: w_exit = SIDE_R;
         4'b1000: w_exit = SIDE_D;
         default: w_exit = SIDE_L;
      endcase
      case (w_exit)
         SIDE_L: begin
            w_off_grid = (r_cur_x == 4'd0);
            w_nbr_x    = r_cur_x - 4'd1;
         end
         SIDE_U: begin
            w_off_grid = (r_cur_y == 4'd0);
            w_nbr_y    = r_cur_y - 4'd1;
         end
         SIDE_R: begin
            w_off_grid = (r_cur_x == LP_X_MAX);
            w_nbr_x    = r_cur_x + 4'd1;
         end
         default: begin
            w_off_grid = (r_cur_y == LP_Y_MAX);
            w_nbr_y    = r_cur_y + 4'd1;
         end
      endcase
      w_at_end  = (r_cur_x == LP_END_X) && (r_cur_y == LP_END_Y);
      w_cnt_inc = r_cnt + 6'd1;
   end

   // Next-state selection and state-decoded outputs.
   always_comb begin
      w_next_state = r_state;
      o_rd_req     = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next_state = S_REQ;
         end
         S_REQ: begin
            o_rd_req = 1'b1;
            o_busy   = 1'b1;
            if (i_rd_gnt) w_next_state = S_WAIT;
         end
         S_WAIT: begin
            o_busy       = 1'b1;
            w_next_state = S_EVAL;
         end
         S_EVAL: begin
            o_busy = 1'b1;
            if (!w_entry_ok)                       w_next_state = S_FAIL;
            else if (w_at_end && w_exit == SIDE_R) w_next_state = S_PASS;
            else if (w_off_grid)                   w_next_state = S_FAIL;
            else if (w_cnt_inc == LP_MAX)          w_next_state = S_FAIL;
            else                                   w_next_state = S_REQ;
         end
         S_PASS: begin
            o_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         S_FAIL: begin
            o_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   // Trace datapath: cursor, entry side, visit counter and the result fields latched at trace end.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cur_x  <= 4'd0;
         r_cur_y  <= 4'd0;
         r_entry  <= SIDE_L;
         r_pipe   <= 3'd0;
         r_cnt    <= 6'd0;
         r_solved <= 1'b0;
         r_steps  <= 6'd0;
         r_fail_x <= 4'd0;
         r_fail_y <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cur_x  <= 4'd0;
                  r_cur_y  <= 4'd0;
                  r_entry  <= SIDE_L;
                  r_cnt    <= 6'd0;
                  r_steps  <= 6'd0;
                  r_solved <= 1'b0;
               end
            end
            S_WAIT: r_pipe <= i_rd_data;
            S_EVAL: begin
               if (w_next_state == S_REQ) begin
                  r_cur_x <= w_nbr_x;
                  r_cur_y <= w_nbr_y;
                  r_entry <= w_exit ^ 2'd2;
                  r_cnt   <= w_cnt_inc;
               end else begin
                  // Results are latched on the way into PASS/FAIL so they are valid alongside done.
                  r_steps  <= w_entry_ok ? w_cnt_inc : r_cnt;
                  r_solved <= (w_next_state == S_PASS);
                  r_fail_x <= r_cur_x;
                  r_fail_y <= r_cur_y;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_rd_x   = r_cur_x;
   assign o_rd_y   = r_cur_y;
   assign o_solved = r_solved;
   assign o_steps  = r_steps;
   assign o_fail_x = r_fail_x;
   assign o_fail_y = r_fail_y;

endmodule

// File: tb/tb_pipe_flow_tracer.sv
// Directed bench for pipe_flow_tracer: grid model answers reads, table of traces plus hand-written reset sequence.
// Latency checked through busy-cycle and grant counts per trace.
// Backpressure exercised by withholding the grant on the second cell.
module tb_pipe_flow_tracer;

   logic       clk;
   logic       i_reset;
   logic       i_start;
   logic       o_rd_req;
   logic [3:0] o_rd_x;
   logic [3:0] o_rd_y;
   logic       i_rd_gnt;
   logic [2:0] i_rd_data;
   logic       o_busy;
   logic       o_done;
   logic       o_solved;
   logic [5:0] o_steps;
   logic [3:0] o_fail_x;
   logic [3:0] o_fail_y;

   pipe_flow_tracer dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_start   (i_start),
      .o_rd_req  (o_rd_req),
      .o_rd_x    (o_rd_x),
      .o_rd_y    (o_rd_y),
      .i_rd_gnt  (i_rd_gnt),
      .i_rd_data (i_rd_data),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_solved  (o_solved),
      .o_steps   (o_steps),
      .o_fail_x  (o_fail_x),
      .o_fail_y  (o_fail_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grid model, index y*6+x; the addressed cell stays on rd_data, so it is valid the cycle after grant.
   logic [2:0] grid [36];
   always_comb begin
      i_rd_data = 3'd0;
      if (o_rd_x < 4'd6 && o_rd_y < 4'd6) i_rd_data = grid[int'(o_rd_y) * 6 + int'(o_rd_x)];
   end

   int n_err;
   int n_checks;

   typedef struct {
      string name;
      int    grid_id;
      int    stall;
      bit    mid_start;
      int    exp_solved;
      int    exp_steps;
      int    exp_fx;
      int    exp_fy;
      int    exp_busy;
      int    exp_reqs;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_cell(input int x, input int y, input logic [2:0] code);
      grid[y * 6 + x] = code;
   endtask

   task automatic fill(input int id);
      for (int i = 0; i < 36; i++) grid[i] = 3'd0;
      case (id)
         1: for (int i = 0; i < 36; i++) grid[i] = 3'd1;
         2, 6: begin
            for (int x = 0; x < 5; x++) set_cell(x, 0, 3'd1);
            set_cell(5, 0, 3'd5);
            for (int y = 1; y < 5; y++) set_cell(5, y, 3'd2);
            set_cell(5, 5, (id == 2) ? 3'd3 : 3'd2);
         end
         3: set_cell(0, 0, 3'd2);
         4: begin
            set_cell(0, 0, 3'd1);
            set_cell(1, 0, 3'd6);
         end
         7: begin
            // Serpentine through all 36 cells, last cell turns back up into the grid.
            for (int y = 0; y < 6; y++) begin
               for (int x = 1; x < 5; x++) set_cell(x, y, 3'd1);
               if (y % 2 == 0) begin
                  set_cell(0, y, (y == 0) ? 3'd1 : 3'd3);
                  set_cell(5, y, 3'd5);
               end else begin
                  set_cell(5, y, 3'd6);
                  set_cell(0, y, (y == 5) ? 3'd3 : 3'd4);
               end
            end
         end
         default: ;
      endcase
   endtask

   function automatic vec_t mk(input string name, input int gid, input int stall, input bit ms,
                               input int sol, input int st, input int fx, input int fy,
                               input int busy, input int reqs);
      vec_t v;
      v.name = name; v.grid_id = gid; v.stall = stall; v.mid_start = ms;
      v.exp_solved = sol; v.exp_steps = st; v.exp_fx = fx; v.exp_fy = fy;
      v.exp_busy = busy; v.exp_reqs = reqs;
      return v;
   endfunction

   task automatic run_trace(input vec_t v);
      int  busy_cnt;
      int  reqs;
      int  stall_left;
      int  stable;
      bit  stalling;
      bit  got_done;
      fill(v.grid_id);
      busy_cnt   = 0;
      reqs       = 0;
      stall_left = v.stall;
      stable     = 0;
      stalling   = 1'b0;
      got_done   = 1'b0;
      i_rd_gnt   = 1'b1;
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check({v.name, "_steps_cleared"}, int'(o_steps), 0);
      check({v.name, "_solved_cleared"}, int'(o_solved), 0);
      for (int cyc = 0; cyc < 1000; cyc++) begin
         if (o_done) begin
            got_done = 1'b1;
            break;
         end
         if (o_busy) busy_cnt++;
         i_start = 1'b0;
         if (!stalling && v.stall > 0 && o_rd_req && o_rd_x == 4'd1 && o_rd_y == 4'd0)
            stalling = 1'b1;
         if (stalling && stall_left > 0) begin
            i_rd_gnt = 1'b0;
            if (o_rd_req && o_rd_x == 4'd1 && o_rd_y == 4'd0) stable++;
            if (v.mid_start && stall_left == 3) i_start = 1'b1;
            stall_left--;
         end else begin
            i_rd_gnt = 1'b1;
         end
         if (o_rd_req && i_rd_gnt) reqs++;
         @(negedge clk);
      end
      i_start  = 1'b0;
      i_rd_gnt = 1'b1;
      check({v.name, "_done_seen"}, int'(got_done), 1);
      check({v.name, "_solved"}, int'(o_solved), v.exp_solved);
      check({v.name, "_steps"}, int'(o_steps), v.exp_steps);
      check({v.name, "_fail_x"}, int'(o_fail_x), v.exp_fx);
      check({v.name, "_fail_y"}, int'(o_fail_y), v.exp_fy);
      check({v.name, "_busy_cycles"}, busy_cnt, v.exp_busy);
      check({v.name, "_grants"}, reqs, v.exp_reqs);
      if (v.stall > 0) check({v.name, "_req_stable"}, stable, v.stall);
      @(negedge clk);
      check({v.name, "_done_pulse"}, int'(o_done), 0);
      repeat (2) @(negedge clk);
      check({v.name, "_busy_idle"}, int'(o_busy), 0);
      check({v.name, "_steps_hold"}, int'(o_steps), v.exp_steps);
      check({v.name, "_solved_hold"}, int'(o_solved), v.exp_solved);
   endtask

   initial begin
      n_err    = 0;
      n_checks = 0;
      i_reset  = 1'b1;
      i_start  = 1'b1;
      i_rd_gnt = 1'b0;
      fill(0);

      vecs[0] = mk("all_ones",    1, 0, 1'b0, 0,  6, 5, 0,  18,  6);
      vecs[1] = mk("solved",      2, 0, 1'b0, 1, 11, 5, 5,  33, 11);
      vecs[2] = mk("blocked",     3, 0, 1'b0, 0,  0, 0, 0,   3,  1);
      vecs[3] = mk("off_grid_up", 4, 0, 1'b0, 0,  2, 1, 0,   6,  2);
      vecs[4] = mk("gnt_stall",   2, 5, 1'b1, 1, 11, 5, 5,  38, 11);
      vecs[5] = mk("wrong_exit",  6, 0, 1'b0, 0, 11, 5, 5,  33, 11);
      vecs[6] = mk("step_cap",    7, 0, 1'b0, 0, 36, 0, 5, 108, 36);

      // Reset state, with start asserted alongside reset.
      repeat (2) @(negedge clk);
      i_start = 1'b0;
      @(negedge clk);
      check("rst_rd_req", int'(o_rd_req), 0);
      check("rst_busy",   int'(o_busy), 0);
      check("rst_done",   int'(o_done), 0);
      check("rst_solved", int'(o_solved), 0);
      check("rst_steps",  int'(o_steps), 0);
      check("rst_fail_x", int'(o_fail_x), 0);
      check("rst_fail_y", int'(o_fail_y), 0);
      check("rst_rd_x",   int'(o_rd_x), 0);
      check("rst_rd_y",   int'(o_rd_y), 0);
      i_reset = 1'b0;

      // Reset while waiting for a grant drops the request immediately.
      fill(1);
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_req_before", int'(o_rd_req), 1);
      check("midrst_busy_before", int'(o_busy), 1);
      i_reset = 1'b1;
      @(negedge clk);
      check("midrst_rd_req", int'(o_rd_req), 0);
      check("midrst_busy",   int'(o_busy), 0);
      check("midrst_done",   int'(o_done), 0);
      i_reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_trace(vecs[i]);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
